fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the bubble instruction and the
// fetch state encoding, used by both the fetch unit and the decoder.
package cpu_pkg;

  // Reserved opcode carried by bubbles; the decoder treats it as a no-op.
  localparam logic [4:0] OpBubble    = 5'b11011;
  localparam logic [8:0] BubbleInstr = {OpBubble, 4'b0000};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and holds
// the IF/ID register feeding the decoder.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [8:0]      BUBBLE   = BubbleInstr
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            halt,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [8:0]      instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            valid_out,
  output logic            done,
  output logic [15:0]     fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      instr_q, instr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic [15:0]     count_q, count_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    count_d  = count_q;
    case (state_q)
      StIdle, StHalted: begin
        instr_d = BUBBLE;
        valid_d = 1'b0;
        // Restart from HALTED keeps the fetch count.
        if (run) begin
          state_d = StRun;
          pc_d    = RESET_PC;
        end
      end
      StRun: begin
        // A halt only counts when it was decoded from a real instruction.
        if (halt && valid_q) begin
          state_d = StHalted;
          instr_d = BUBBLE;
          valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          instr_d = BUBBLE;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d  = imem_data;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 1'b1;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        instr_d = BUBBLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= BUBBLE;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign valid_out   = valid_q;
  assign done        = (state_q == StHalted);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the expected IF/ID contents,
// a negedge monitor compares whenever valid_out is high.
module tb_fetch_unit;

  localparam logic [8:0] Bub = 9'b110110000;

  logic       clk = 1'b0;
  logic       rst_n, run, halt, stall, branch_taken;
  logic [7:0] branch_target, imem_addr, pc_out;
  logic [8:0] imem_data, instr_out;
  logic       valid_out, done;
  logic [15:0] fetch_count;

  logic [8:0]  mem [256];
  logic [16:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .halt         (halt),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .done         (done),
    .fetch_count  (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock; queue the IF/ID contents that edge should produce.
  task automatic cyc(input logic exp_v, input logic [8:0] exp_i, input logic [7:0] exp_pc);
    @(posedge clk);
    #1;
    if (exp_v) exp_q.push_back({exp_i, exp_pc});
  endtask

  // Monitor
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got instr %0h pc %0h expected no valid",
                 instr_out, pc_out);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("sb_instr", 32'(instr_out), 32'(e[16:8]));
        check("sb_pc", 32'(pc_out), 32'(e[7:0]));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_instr"}, 32'(instr_out), 32'(Bub));
    check({tag, "_pc_out"}, 32'(pc_out), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_count"}, 32'(fetch_count), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'h100 | 9'(i);
    mem[0] = 9'h0A5;
    mem[1] = 9'h011;
    rst_n = 1'b0; run = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    #1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check_reset_outputs("reset");

    // Scenario 1: run pulse, sequential fetch
    rst_n = 1'b1;
    run = 1'b1;
    cyc(0, 0, 0);
    run = 1'b0;
    cyc(1, 9'h0A5, 8'h00);
    cyc(1, 9'h011, 8'h01);
    cyc(1, 9'h102, 8'h02);
    check("s1_count", 32'(fetch_count), 32'd3);

    // Scenario 3: stall holds everything, then stall+branch takes the branch
    stall = 1'b1;
    cyc(1, 9'h102, 8'h02);
    cyc(1, 9'h102, 8'h02);
    cyc(1, 9'h102, 8'h02);
    check("s3_stall_count", 32'(fetch_count), 32'd3);
    check("s3_stall_pc", 32'(imem_addr), 32'h03);
    branch_taken = 1'b1; branch_target = 8'h40;
    cyc(0, 0, 0);
    check("s3_branch_pc", 32'(imem_addr), 32'h40);
    check("s3_branch_instr", 32'(instr_out), 32'(Bub));
    stall = 1'b0; branch_taken = 1'b0;
    cyc(1, 9'h140, 8'h40);
    check("s3_count", 32'(fetch_count), 32'd4);

    // Scenario 2: branch at pc=5 to 0x20
    branch_taken = 1'b1; branch_target = 8'h05;
    cyc(0, 0, 0);
    check("s2_pc5", 32'(imem_addr), 32'h05);
    branch_target = 8'h20;
    cyc(0, 0, 0);
    check("s2_branch_pc", 32'(imem_addr), 32'h20);
    check("s2_branch_instr", 32'(instr_out), 32'(Bub));
    check("s2_branch_valid", 32'(valid_out), 32'd0);
    branch_taken = 1'b0;
    cyc(1, 9'h120, 8'h20);
    check("s2_count", 32'(fetch_count), 32'd5);

    // Scenario 4: halt+branch takes halt; halted ignores inputs; restart keeps count
    halt = 1'b1; branch_taken = 1'b1; branch_target = 8'h77;
    cyc(0, 0, 0);
    check("s4_done", 32'(done), 32'd1);
    check("s4_pc_frozen", 32'(imem_addr), 32'h21);
    check("s4_instr", 32'(instr_out), 32'(Bub));
    halt = 1'b0; branch_target = 8'h99; stall = 1'b1;
    cyc(0, 0, 0);
    check("s4_halted_pc", 32'(imem_addr), 32'h21);
    check("s4_halted_done", 32'(done), 32'd1);
    branch_taken = 1'b0; stall = 1'b0;
    run = 1'b1;
    cyc(0, 0, 0);
    run = 1'b0;
    check("s4_restart_pc", 32'(imem_addr), 32'h00);
    check("s4_restart_done", 32'(done), 32'd0);
    check("s4_count_kept", 32'(fetch_count), 32'd5);
    cyc(1, 9'h0A5, 8'h00);
    check("s4_count", 32'(fetch_count), 32'd6);

    // Scenario 5: wrap FE, FF, 00; run during RUN is ignored
    branch_taken = 1'b1; branch_target = 8'hFE;
    cyc(0, 0, 0);
    branch_taken = 1'b0;
    run = 1'b1;
    cyc(1, 9'h1FE, 8'hFE);
    run = 1'b0;
    cyc(1, 9'h1FF, 8'hFF);
    cyc(1, 9'h0A5, 8'h00);
    check("s5_pc_wrapped", 32'(imem_addr), 32'h01);
    check("s5_count", 32'(fetch_count), 32'd9);

    // Scenario 6: reset mid-RUN during a stall
    stall = 1'b1;
    cyc(1, 9'h0A5, 8'h00);
    rst_n = 1'b0; run = 1'b1;
    cyc(0, 0, 0);
    check_reset_outputs("s6");
    rst_n = 1'b1; run = 1'b0; stall = 1'b0;
    cyc(0, 0, 0);
    check("s6_idle_valid", 32'(valid_out), 32'd0);
    check("s6_idle_pc", 32'(imem_addr), 32'h00);
    run = 1'b1;
    cyc(0, 0, 0);
    run = 1'b0;
    cyc(1, 9'h0A5, 8'h00);
    cyc(1, 9'h011, 8'h01);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
